// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count and programmable
// almost-full / almost-empty thresholds. The read port is either registered
// (FWFT=0) or first-word-fall-through (FWFT=1).
//
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN
//   defined   -> sticky overflow/underflow flags, cleared only by reset
//   undefined -> overflow/underflow tied to 0, ports kept for a stable interface
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   w_en         write request (accepted when not full)
//   r_en         read request / FWFT pop (accepted when not empty)
//   data_in      write data
//   data_out     read data (registered, or combinational head word in FWFT)
//   full, empty  occupancy extremes
//   almost_full  count >= AF_THRESH
//   almost_empty count <= AE_THRESH
//   count        occupancy 0..DEPTH
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0] AF_LVL  = (PTR_WIDTH+1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_LVL  = (PTR_WIDTH+1)'(AE_THRESH);
  localparam logic [PTR_WIDTH:0] PTR_ONE = (PTR_WIDTH+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_WIDTH:0]    w_ptr_q, w_ptr_d;
  logic [PTR_WIDTH:0]    r_ptr_q, r_ptr_d;
  logic [PTR_WIDTH-1:0]  w_addr, r_addr;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_acc, rd_acc;

  assign w_addr = w_ptr_q[PTR_WIDTH-1:0];
  assign r_addr = r_ptr_q[PTR_WIDTH-1:0];

  // Flags and count describe the state at the start of the cycle.
  always_comb begin
    empty        = (w_ptr_q == r_ptr_q);
    full         = (w_ptr_q[PTR_WIDTH] != r_ptr_q[PTR_WIDTH]) && (w_addr == r_addr);
    count        = w_ptr_q - r_ptr_q;
    almost_full  = (count >= AF_LVL);
    almost_empty = (count <= AE_LVL);
  end

  // Full/empty are sampled before this cycle's read/write, so a write into a
  // full FIFO is refused even if a read frees a slot on the same edge.
  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (wr_acc) w_ptr_d = w_ptr_q + PTR_ONE;
    if (rd_acc) r_ptr_d = r_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem_q[w_addr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented as soon as it exists; zero when nothing is held.
      always_comb begin
        data_out = '0;
        if (!empty) data_out = mem_q[r_addr];
      end
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (rd_acc) dout_d = mem_q[r_addr];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
      end

      assign data_out = dout_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (w_en & full);
    underflow_d = underflow_q | (r_en & empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout_a, dout_b;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic       full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [4:0] count_a, count_b;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .data_in(din),
    .data_out(dout_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .count(count_a), .overflow(ovf_a), .underflow(unf_a)
  );

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .data_in(din),
    .data_out(dout_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .count(count_b), .overflow(ovf_b), .underflow(unf_b)
  );

  // Reference model: a queue holding the FIFO contents in order.
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  bit         m_ovf, m_unf;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit rn, input bit w, input bit r, input logic [7:0] d);
    int n;
    n = mq.size();
    if (!rn) begin
      mq.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      if (w && n == DEPTH) m_ovf = 1'b1;
      if (r && n == 0)     m_unf = 1'b1;
      if (r && n > 0)      m_dout = mq.pop_front();
      if (w && n < DEPTH)  mq.push_back(d);
    end
  endtask

  task automatic check_all();
    int n;
    logic [7:0] head;
    n = mq.size();
    head = (n > 0) ? mq[0] : 8'h00;
    chk("count_a", count_a, n);
    chk("count_b", count_b, n);
    chk("empty_a", empty_a, n == 0);
    chk("empty_b", empty_b, n == 0);
    chk("full_a", full_a, n == DEPTH);
    chk("full_b", full_b, n == DEPTH);
    chk("almost_full_a", af_a, n >= AF);
    chk("almost_full_b", af_b, n >= AF);
    chk("almost_empty_a", ae_a, n <= AE);
    chk("almost_empty_b", ae_b, n <= AE);
    chk("data_out_reg", dout_a, m_dout);
    chk("data_out_fwft", dout_b, head);
    chk("overflow_a", ovf_a, m_ovf & ERR_EN);
    chk("underflow_a", unf_a, m_unf & ERR_EN);
    chk("overflow_b", ovf_b, m_ovf & ERR_EN);
    chk("underflow_b", unf_b, m_unf & ERR_EN);
  endtask

  task automatic step(input bit rn, input bit w, input bit r, input logic [7:0] d);
    rst_n = rn;
    w_en  = w;
    r_en  = r;
    din   = d;
    @(posedge clk);
    model_update(rn, w, r, d);
    #1;
    check_all();
  endtask

  typedef struct {
    bit         w;
    bit         r;
    logic [7:0] d;
    int         exp_cnt;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'h11, 1, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 8'h22, 2, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 8'h33, 3, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 8'h44, 3, 8'h11};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 2, 8'h22};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 1, 8'h33};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 0, 8'h44};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 0, 8'h44};
    tbl[8] = '{1'b1, 1'b1, 8'h55, 1, 8'h44};
    tbl[9] = '{1'b0, 1'b1, 8'h00, 0, 8'h55};

    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'hEE);
    chk("rst_count", count_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_almost_empty", ae_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_dout", dout_a, 0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      step(1'b1, tbl[i].w, tbl[i].r, tbl[i].d);
      chk($sformatf("tbl%0d_count", i), count_a, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_dout", i), dout_a, tbl[i].exp_dout);
    end
    chk("tbl_underflow", unf_a, ERR_EN);

    // Fill to full, then a rejected write
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(i));
      chk("fill_almost_full", af_a, i >= 14);
    end
    chk("fill_full", full_a, 1);
    chk("fill_count", count_a, 16);
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    chk("ovf_count", count_a, 16);
    chk("ovf_flag", ovf_a, ERR_EN);

    // Drain in order, then an extra read
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("drain_dout", dout_a, i);
    end
    chk("drain_empty", empty_a, 1);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("unf_dout", dout_a, 8'h10);
    chk("unf_flag", unf_a, ERR_EN);

    // Steady-state streaming across several pointer wraps
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'(8'h88 + i));
      chk("stream_count", count_a, 8);
      chk("stream_dout", dout_a, 8'(8'h80 + i));
    end

    // Simultaneous read/write at full and at empty
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
    chk("both_pre_full", full_a, 1);
    step(1'b1, 1'b1, 1'b1, 8'h3C);
    chk("both_full_count", count_a, 15);
    while (mq.size() > 0) step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h77);
    chk("both_empty_count", count_a, 1);
    chk("both_empty_dout", dout_a, 8'hC7);

    // FWFT presentation
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h5A);
    chk("fwft_empty", empty_b, 0);
    chk("fwft_dout", dout_b, 8'h5A);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("fwft_pop_empty", empty_b, 1);
    chk("fwft_pop_dout", dout_b, 8'h00);

    // Reset mid-stream discards contents and ignores that cycle's write
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hD0 + i));
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 8'hEE);
    chk("midrst_count", count_a, 0);
    chk("midrst_empty", empty_a, 1);
    chk("midrst_dout", dout_a, 0);
    chk("midrst_ovf", ovf_a, 0);
    step(1'b1, 1'b1, 1'b0, 8'h99);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("midrst_new_data", dout_a, 8'h99);

    // Randomized traffic with phases biased toward full and toward empty
    for (int i = 0; i < 3000; i++) begin
      int wp;
      bit rn, w, r;
      wp = ((i / 200) % 3 == 0) ? 80 : (((i / 200) % 3 == 1) ? 20 : 50);
      rn = ($urandom_range(0, 499) != 0);
      w  = ($urandom_range(0, 99) < wp);
      r  = ($urandom_range(0, 99) < (100 - wp));
      step(rn, w, r, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
